// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: FSM encodings and handshake levels.
// Imported by div.sv (optional early exit: DIV_EARLY_EXIT_EN).
package div_pkg;

    localparam int REG_W = 32;
    localparam int DREG_W = 64;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    function automatic logic [REG_W-1:0] mag(
        input logic [REG_W-1:0] x,
        input logic             s
    );
        return (s && x[REG_W-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider answering EX's start/ready handshake.
// Define DIV_EARLY_EXIT_EN to finish in two edges when |divisor| > |dividend|.
module div
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                signed_div_i,
    input  logic [REG_W-1:0]    opdata1_i,
    input  logic [REG_W-1:0]    opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [DREG_W-1:0]   result_o,
    output logic                ready_o
);

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [REG_W-1:0] dvd;
    logic [REG_W-1:0] dvs;
    logic [REG_W-1:0] rem;
    logic             neg_q;
    logic             neg_r;

    logic [REG_W-1:0] mag1;
    logic [REG_W-1:0] mag2;
    logic [REG_W:0]   rem_s;
    logic [REG_W:0]   trial;
    logic             trial_ok;
    logic [REG_W-1:0] next_q;
    logic [REG_W-1:0] next_rem;
    logic [REG_W-1:0] fin_q;
    logic [REG_W-1:0] fin_r;

    assign mag1 = mag(opdata1_i, signed_div_i);
    assign mag2 = mag(opdata2_i, signed_div_i);

    // dvd shifts out dividend bits on the left and collects quotient bits on the right
    assign rem_s    = {rem, dvd[REG_W-1]};
    assign trial    = rem_s - {1'b0, dvs};
    assign trial_ok = ~trial[REG_W];
    assign next_q   = {dvd[REG_W-2:0], trial_ok};
    assign next_rem = trial_ok ? trial[REG_W-1:0] : rem_s[REG_W-1:0];

    assign fin_q = neg_q ? (~dvd + 1'b1) : dvd;
    assign fin_r = neg_r ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == '0) begin
                            dvd   <= '0;
                            state <= DIV_BY_ZERO;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        // Short path reuses DIV_BY_ZERO so ready keeps the two-edge timing
                        else if (mag2 > mag1) begin
                            dvd   <= opdata1_i;
                            state <= DIV_BY_ZERO;
                        end
`endif
                        else begin
                            dvd   <= mag1;
                            dvs   <= mag2;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= signed_div_i &
                                     (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                            neg_r <= signed_div_i & opdata1_i[REG_W-1];
                            state <= DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    result_o <= {dvd, {REG_W{1'b0}}};
                    ready_o  <= DIV_RESULT_READY;
                    state    <= DIV_END;
                end
                DIV_ON: begin
                    if (annul_i || start_i == DIV_STOP) begin
                        cnt   <= '0;
                        state <= DIV_FREE;
                    end else if (cnt != 6'd32) begin
                        dvd <= next_q;
                        rem <= next_rem;
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {fin_r, fin_q};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (annul_i || start_i == DIV_STOP) begin
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        state    <= DIV_FREE;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected results queued at start, checked at ready.
// Honours DIV_EARLY_EXIT_EN for the expected latency.
module tb_div;

    logic        clk;
    logic        rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    div dut (
        .clk(clk),
        .rst_n(rst_n),
        .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .start_i(start_i),
        .annul_i(annul_i),
        .result_o(result_o),
        .ready_o(ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 0) return 64'h0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 64'h0000_0000_8000_0000;
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int lat(input logic [31:0] a, input logic [31:0] b,
                               input logic s);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        if (mb > ma) return 2;
`else
        if (ma == 32'hFFFF_FFFF && mb == 32'hFFFF_FFFF) return 34;
`endif
        return 34;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that raised ready
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
        int n;
        int exp_lat;
        logic [63:0] exp;
        exp_lat = lat(a, b, s);
        sb_q.push_back(model(a, b, s));
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        n = 61;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~s;
            end
            if (ready_o) begin
                n = i;
                break;
            end
        end
        exp = sb_q.pop_front();
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, result_o, exp);
    endtask

    task automatic release_start(input string tag);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rdy_drop"}, 64'(ready_o), 64'h0);
        check({tag, "_res_drop"}, result_o, 64'h0);
    endtask

    initial begin
        rst_n        = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_o), 64'h0);
        check("rst_result", result_o, 64'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        run_op("u100_7", 32'd100, 32'd7, 1'b0);
        check("u100_7_const", result_o, 64'h0000_0002_0000_000E);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", 64'(ready_o), 64'h1);
            check("hold_res", result_o, 64'h0000_0002_0000_000E);
        end
        release_start("u100_7");

        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("s_m7_2_const", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        release_start("s_m7_2");

        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("s_ovf_const", result_o, 64'h0000_0000_8000_0000);
        release_start("s_ovf");

        run_op("dbz", 32'd5, 32'd0, 1'b0);
        release_start("dbz");

        run_op("u3_10", 32'd3, 32'd10, 1'b0);
        check("u3_10_const", result_o, 64'h0000_0003_0000_0000);
        release_start("u3_10");

        run_op("s_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1);
        release_start("s_m3_10");

        run_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);
        release_start("s_100_m7");

        run_op("u_big", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        release_start("u_big");

        for (int k = 0; k < 4; k++) begin
            run_op("rand", $urandom, $urandom_range(1, 50000), k[0]);
            release_start("rand");
        end

        // annul at iteration 10
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_rdy", 64'(ready_o), 64'h0);
        repeat (30) @(posedge clk);
        #1;
        check("annul_rdy_late", 64'(ready_o), 64'h0);
        check("annul_res_late", result_o, 64'h0);
        run_op("after_annul", 32'd9, 32'd3, 1'b0);
        check("after_annul_const", result_o, 64'h0000_0000_0000_0003);
        release_start("after_annul");

        // async reset between edges at iteration 20
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_rdy", 64'(ready_o), 64'h0);
        check("arst_res", result_o, 64'h0);
        start_i = 1'b0;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("arst_idle_rdy", 64'(ready_o), 64'h0);
        run_op("after_rst", 32'd100, 32'd7, 1'b0);
        release_start("after_rst");

        check("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider; the responder end of the execute stage's divide handshake.
- Accepts operands plus start and signed-mode from EX, then produces {remainder, quotient} after a fixed radix-2 restoring iteration.
- Holds ready until EX drops start.
- EX writes the result: HI = remainder = result_o[63:32], LO = quotient = result_o[31:0].

Parameters:
- None. Width is fixed at 32 (`RegBus); result width is 64 (`DoubleRegBus).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-high: asserted when rst_n == `RstEnable (1'b1).
- signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  `DivStart / `DivStop from EX; held high until ready seen.
- annul_i  input  1  pipeline flush; cancels any operation in progress.
- result_o  output  64  {remainder, quotient}.
- ready_o  output  1  `DivResultReady / `DivResultNotReady.

Behaviour:
- Reset (async, immediate): state = DivFree, cnt = 0, result_o = 0, ready_o = `DivResultNotReady, internal dividend/divisor/partial-remainder = 0. Reset mid-operation discards everything.
- States (2-bit encodings in the shared package): DivFree, DivByZero, DivOn, DivEnd.
- DivFree:
  - start_i = DivStart, annul_i = 0, opdata2_i != 0: latch operands and signed_div_i. When signed, latch magnitudes (~x+1 if bit31 set). Partial remainder = 0, cnt = 0, go to DivOn.
  - start_i = DivStart, annul_i = 0, opdata2_i == 0: go to DivByZero.
  - Otherwise stay; ready_o = 0, result_o = 0.
- DivByZero: next edge go to DivEnd with quotient = 0, remainder = 0. Total of 2 edges after first start edge until ready_o = 1.
- DivOn, per edge while cnt < 32:
  - shift {rem, dvd} left 1;
  - trial = rem_shifted − divisor (33-bit);
  - if trial is non-negative, rem = trial and quotient bit = 1, else quotient bit = 0;
  - cnt++.
- DivOn, edge with cnt == 32:
  - Apply signs when signed: quotient negated if dividend and divisor signs differ; remainder negated if dividend negative.
  - Load result_o, set ready_o = DivResultReady, go to DivEnd.
- DivOn abort: if annul_i = 1 or start_i = DivStop, go to DivFree with cnt = 0. ready_o is never raised. Abort has priority over iteration.
- Latency: ready_o rises on the 34th rising edge counting the edge that first samples start in DivFree; result_o is valid the same cycle.
- DivEnd:
  - start_i = DivStart: hold result_o and ready_o.
  - start_i = DivStop: next edge go to DivFree with ready_o = 0 and result_o = 0.
  - annul_i in DivEnd behaves like DivStop.
- Operands change while in DivOn: ignored, since latched copies are used.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no exception.
- Unsigned mode: no magnitude or sign fixup at all.
- Back-to-back: a new start is accepted only from DivFree, so there is a minimum one-cycle gap after DivEnd.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in DivFree, if the latched divisor magnitude is greater than the dividend magnitude (unsigned compare), skip DivOn and go directly to DivEnd. Quotient = 0 and remainder = dividend, keeping the original signed value. ready_o rises on edge 2, same as the divide-by-zero path.
- Undefined: all non-zero-divisor operations take the full 34-edge latency.

Decomposition:
- Add to macro.v (shared):
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivResultReady 1'b1, DivResultNotReady 1'b0;
  - DivStart 1'b1, DivStop 1'b0.
- RstEnable, ZeroWord, RegBus and DoubleRegBus already exist.
- Single module; no sub-module is warranted. The iteration step is one 33-bit subtract kept inline.

Test Plan:
- Unsigned: opdata1 = 100, opdata2 = 7, signed = 0, start held → ready_o = 1 on edge 34; result_o = 0x00000002_0000000E.
- Signed: opdata1 = 0xFFFFFFF9 (−7), opdata2 = 2, signed = 1 → result_o = 0xFFFFFFFF_FFFFFFFD (rem −1, quot −3) on edge 34. Also 0x80000000 / 0xFFFFFFFF signed → 0x00000000_80000000.
- Divide by zero: opdata1 = 5, opdata2 = 0 → ready_o = 1 on edge 2; result_o = 0.
- Annul: start 100/7, assert annul_i for one cycle at iteration 10 → ready_o stays 0, state returns to DivFree. A fresh 9/3 start then yields 0x00000000_00000003 after 34 edges.
- Handshake hold/release: keep start high 5 cycles after ready → result_o and ready_o stable. Drop start → next edge ready_o = 0 and result_o = 0.
- Async reset asserted at iteration 20, between clock edges → outputs zero immediately. After release, 100/7 completes normally.
- With DIV_EARLY_EXIT_EN: 3 / 10 unsigned → ready on edge 2, result_o = 0x00000003_00000000.
